// File: rtl/reset_sequencer.sv
// Staged reset release sequencer.
// Releases N reset domains one after another: each stage waits DELAY
// cycles, drops its reset, then waits up to TIMEOUT cycles for its Ready
// acknowledge. Once all stages are up, Ready is supervised continuously and
// any loss of Ready forces ERROR, which holds until a Restart pulse.
module reset_sequencer #(
  parameter int N       = 4,
  parameter int DELAY   = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         Por_Reset,
  input  logic [N-1:0] Ready,
  input  logic         Restart,
  output logic [N-1:0] Stage_Reset,
  output logic         Done,
  output logic         Error,
  output logic [2:0]   Fail_Stage
);

  localparam int              KW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0]     DLY_LAST = 16'(DELAY - 1);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [KW-1:0]   K_LAST   = KW'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_WAIT_RDY,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   w_k_nxt;
  logic [15:0]     r_cnt;
  logic [15:0]     w_cnt_nxt;

  logic            r_por_meta;
  logic            r_por_s;

  logic [N-1:0]    r_stage_rst;
  logic [N-1:0]    w_stage_rst_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic [2:0]      r_fail;
  logic [2:0]      w_fail_nxt;
  logic [2:0]      w_low_bad;
  logic            w_found;

  assign Stage_Reset = r_stage_rst;
  assign Done        = r_done;
  assign Error       = r_err;
  assign Fail_Stage  = r_fail;

  // Two-flop synchronizer for the asynchronous power-up reset; resets to "asserted".
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_por_meta <= 1'b1;
      r_por_s    <= 1'b1;
    end else begin
      r_por_meta <= Por_Reset;
      r_por_s    <= r_por_meta;
    end
  end

  // State register together with the registered outputs.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_cnt       <= '0;
      r_stage_rst <= '1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_fail      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_cnt       <= w_cnt_nxt;
      r_stage_rst <= w_stage_rst_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  // Next-state, stage index and counter; the counter restarts at every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_k_nxt   = '0;
        w_cnt_nxt = '0;
        if (!r_por_s) begin
          w_state_nxt = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (r_por_s) begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DLY_LAST) begin
          w_state_nxt = ST_WAIT_RDY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_WAIT_RDY: begin
        // Ready wins over a timeout landing on the same cycle.
        if (r_por_s) begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = '0;
          w_cnt_nxt   = '0;
        end else if (Ready[r_k]) begin
          w_cnt_nxt = '0;
          if (r_k == K_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DELAY;
            w_k_nxt     = r_k + KW'(1);
          end
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = ST_ERROR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_DONE: begin
        if (r_por_s) begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = '0;
          w_cnt_nxt   = '0;
        end else if (!(&Ready)) begin
          w_state_nxt = ST_ERROR;
          w_cnt_nxt   = '0;
        end
      end
      ST_ERROR: begin
        if (Restart) begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_k_nxt     = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output next values, derived from the transition being taken this cycle.
  always_comb begin
    w_stage_rst_nxt = r_stage_rst;
    w_fail_nxt      = r_fail;
    w_low_bad       = '0;
    w_found         = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!Ready[j] && !w_found) begin
        w_low_bad = 3'(j);
        w_found   = 1'b1;
      end
    end

    if (w_state_nxt == ST_IDLE || w_state_nxt == ST_ERROR) begin
      w_stage_rst_nxt = '1;
    end else if (r_state == ST_DELAY && w_state_nxt == ST_WAIT_RDY) begin
      w_stage_rst_nxt[r_k] = 1'b0;
    end

    w_done_nxt = (w_state_nxt == ST_DONE);
    w_err_nxt  = (w_state_nxt == ST_ERROR);

    if (r_state == ST_DONE && w_state_nxt == ST_ERROR) begin
      w_fail_nxt = w_low_bad;
    end else if (r_state == ST_WAIT_RDY && w_state_nxt == ST_ERROR) begin
      w_fail_nxt = 3'(r_k);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus drives a behavioural model
// and queues expected outputs; a monitor pops and compares after every edge.
module tb_reset_sequencer;

  localparam int N   = 4;
  localparam int DLY = 4;
  localparam int TMO = 8;

  logic         Clk = 1'b0;
  logic         nReset;
  logic         Por_Reset;
  logic [N-1:0] Ready;
  logic         Restart;
  logic [N-1:0] Stage_Reset;
  logic         Done;
  logic         Error;
  logic [2:0]   Fail_Stage;

  always #5 Clk = ~Clk;

  reset_sequencer #(.N(N), .DELAY(DLY), .TIMEOUT(TMO)) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .Por_Reset   (Por_Reset),
    .Ready       (Ready),
    .Restart     (Restart),
    .Stage_Reset (Stage_Reset),
    .Done        (Done),
    .Error       (Error),
    .Fail_Stage  (Fail_Stage)
  );

  typedef struct packed {
    logic [N-1:0] srst;
    logic         done;
    logic         err;
    logic [2:0]   fail;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: number of released stages plus a phase timer.
  bit m_s1, m_s2;
  bit m_idle, m_wait, m_done, m_err;
  int m_rel, m_t, m_fail;

  // Stimulus knobs
  int           lat[N];
  int           age[N];
  logic [N-1:0] drop;
  bit           g_nrst, g_por, g_rst, noise;

  function automatic logic [N-1:0] m_srst();
    int all_m, rel_m;
    all_m = (1 << N) - 1;
    rel_m = (1 << m_rel) - 1;
    return N'(all_m & ~rel_m);
  endfunction

  task automatic model_step(input bit nr, input bit por, input bit rst,
                            input logic [N-1:0] rdy);
    bit ps;
    int bad;
    if (!nr) begin
      m_s1 = 1; m_s2 = 1; m_idle = 1; m_wait = 0; m_done = 0; m_err = 0;
      m_rel = 0; m_t = 0; m_fail = 0;
      return;
    end
    ps   = m_s2;
    m_s2 = m_s1;
    m_s1 = por;
    if (m_err) begin
      if (rst) begin m_err = 0; m_idle = 1; end
    end else if (m_idle) begin
      if (!ps) begin m_idle = 0; m_rel = 0; m_wait = 0; m_t = 0; end
    end else if (ps) begin
      m_idle = 1; m_done = 0; m_wait = 0; m_rel = 0; m_t = 0;
    end else if (m_done) begin
      bad = -1;
      for (int j = N - 1; j >= 0; j--) if (!rdy[j]) bad = j;
      if (bad >= 0) begin
        m_err = 1; m_done = 0; m_wait = 0; m_fail = bad; m_rel = 0;
      end
    end else if (!m_wait) begin
      if (m_t == DLY - 1) begin m_rel++; m_wait = 1; m_t = 0; end
      else m_t++;
    end else begin
      if (rdy[m_rel-1]) begin
        if (m_rel == N) m_done = 1;
        else begin m_wait = 0; m_t = 0; end
      end else if (m_t == TMO - 1) begin
        m_err = 1; m_fail = m_rel - 1; m_rel = 0; m_wait = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge.
  task automatic tick();
    logic [N-1:0] r;
    logic [N-1:0] cur;
    exp_t e;
    @(negedge Clk);
    cur = m_srst();
    for (int j = 0; j < N; j++) begin
      if (cur[j]) age[j] = 0;
      else        age[j]++;
      r[j] = (!cur[j] && age[j] >= lat[j] && !drop[j]) ||
             (noise && cur[j] && ($urandom_range(3) == 0));
    end
    Ready     = r;
    nReset    = g_nrst;
    Por_Reset = g_por;
    Restart   = g_rst;
    model_step(g_nrst, g_por, g_rst, r);
    e.srst = m_srst();
    e.done = m_done;
    e.err  = m_err;
    e.fail = 3'(m_fail);
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic run_to_done();
    for (int c = 0; c < 200 && !m_done; c++) tick();
  endtask

  task automatic pulse_restart();
    g_rst = 1; tick(); g_rst = 0;
  endtask

  task automatic set_lat(input int v);
    for (int j = 0; j < N; j++) lat[j] = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("stage_reset", 32'(Stage_Reset), 32'(e.srst));
        check("done",        32'(Done),        32'(e.done));
        check("error",       32'(Error),       32'(e.err));
        check("fail_stage",  32'(Fail_Stage),  32'(e.fail));
      end
    end
  end

  initial begin
    int por_left;
    nReset = 0; Por_Reset = 0; Restart = 0; Ready = '0;
    g_nrst = 0; g_por = 0; g_rst = 0; noise = 0; drop = '0;
    for (int j = 0; j < N; j++) age[j] = 0;
    set_lat(1);
    m_idle = 1;

    // Reset, then a clean sequence with Ready one cycle after each release
    run(2);
    g_nrst = 1;
    run_to_done();
    run(5);

    // Stage 2 never acknowledges -> timeout, then Restart and rerun
    lat[2] = 1000;
    run(40);
    lat[2] = 1;
    pulse_restart();
    run_to_done();
    run(3);

    // Stage 1 acknowledges on the timeout cycle itself
    pulse_restart();
    g_nrst = 0; tick(); g_nrst = 1;
    lat[1] = TMO;
    run_to_done();
    run(3);

    // Stage 1 one cycle too late -> error on stage 1
    g_nrst = 0; tick(); g_nrst = 1;
    lat[1] = TMO + 1;
    run(40);
    lat[1] = 1;
    pulse_restart();
    run_to_done();

    // In DONE drop Ready[1] and Ready[3] together
    drop = 4'b1010;
    run(3);
    drop = '0;
    pulse_restart();
    run_to_done();

    // Por pulse during stage-2 DELAY
    g_nrst = 0; tick(); g_nrst = 1;
    for (int c = 0; c < 200 && !(m_rel == 2 && !m_wait && !m_idle && !m_err); c++) tick();
    tick();
    g_por = 1; run(3); g_por = 0;
    run_to_done();
    run(2);

    // nReset in DONE and in ERROR
    g_nrst = 0; tick(); g_nrst = 1;
    run(2);
    run_to_done();
    drop = 4'b0100;
    run(3);
    drop = '0;
    g_nrst = 0; tick(); g_nrst = 1;
    run(3);

    // Randomized phase
    noise = 1;
    por_left = 0;
    for (int i = 0; i < 3000; i++) begin
      g_rst = m_err && ($urandom_range(3) == 0);
      if (m_idle) for (int j = 0; j < N; j++) lat[j] = $urandom_range(1, 10);
      if (por_left > 0) begin
        g_por = 1; por_left--;
      end else begin
        g_por = 0;
        if ($urandom_range(149) == 0) por_left = $urandom_range(1, 4);
      end
      if ($urandom_range(59) == 0) drop = N'($urandom);
      else if ($urandom_range(7) == 0) drop = '0;
      g_nrst = ($urandom_range(399) != 0);
      tick();
    end

    @(posedge Clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
